pipeline_reg_chain: RTL

Parametrised, fully registered valid/ready pipeline of DEPTH stages, each stage a two-entry skid buffer. Every output is driven from a flop, so the chain breaks both the forward data/valid path and the backward ready path. It sustains one transfer per cycle and is used to close timing on long valid/ready routes between blocks. It also adds a synchronous flush and an occupancy count.

---
 rtl/pipeline_reg_chain.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipeline_reg_chain.sv
// pipeline_reg_chain
// Fully registered valid/ready pipeline of DEPTH two-entry skid stages.
// Forward valid/data and backward ready are all driven from flops, so the
// chain cuts long handshake routes in both directions while still moving
// one item per cycle. A synchronous flush drops every held entry, and a
// registered occupancy count tracks how many entries are held.
//
// Ports
//   clk        : clock, all state on rising edge
//   resetn     : asynchronous active-low reset
//   flush      : synchronous discard of all held entries (driven from a flop)
//   in_valid   : upstream offers in_data
//   in_ready   : stage 0 skid empty, forced low while flush=1
//   in_data    : upstream payload
//   out_valid  : last stage main entry valid, forced low while flush=1
//   out_ready  : downstream accepts
//   out_data   : last stage main entry data
//   occupancy  : number of valid entries held (0..2*DEPTH)
module pipeline_reg_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0]            m_valid_q, m_valid_d;
  logic [DEPTH-1:0]            s_valid_q, s_valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] m_data_q, m_data_d;
  logic [DEPTH-1:0][WIDTH-1:0] s_data_q, s_data_d;

  logic [DEPTH-1:0]            up_valid_s;
  logic [DEPTH-1:0][WIDTH-1:0] up_data_s;
  logic [DEPTH-1:0]            down_ready_s;
  logic [DEPTH-1:0]            acc_s;
  logic [DEPTH-1:0]            pop_s;

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        in_xfer_s;
  logic                        out_xfer_s;

  // Handshake outputs: flop outputs gated only by flush, which is itself a flop.
  assign in_ready   = ~s_valid_q[0] & ~flush;
  assign out_valid  = m_valid_q[DEPTH-1] & ~flush;
  assign out_data   = m_data_q[DEPTH-1];
  assign occupancy  = cnt_q;

  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid & out_ready;

  // Stage interconnect: stage k sees stage k-1 main entry upstream and
  // stage k+1 skid-empty as its downstream ready.
  always_comb begin
    up_valid_s   = '0;
    up_data_s    = '0;
    down_ready_s = '0;
    // Stage 0 ignores the input during flush so nothing is captured.
    up_valid_s[0]         = in_valid & ~flush;
    up_data_s[0]          = in_data;
    down_ready_s[DEPTH-1] = out_ready;
    for (int k = 1; k < DEPTH; k++) begin
      up_valid_s[k] = m_valid_q[k-1];
      up_data_s[k]  = m_data_q[k-1];
    end
    for (int k = 0; k < DEPTH-1; k++) begin
      down_ready_s[k] = ~s_valid_q[k+1];
    end
  end

  // Per-stage skid buffer next state.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    acc_s     = '0;
    pop_s     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      acc_s[k] = up_valid_s[k] & ~s_valid_q[k];
      pop_s[k] = m_valid_q[k] & down_ready_s[k];
      if (s_valid_q[k]) begin
        // Skid full: ready is low, only refill main from skid on a pop.
        if (pop_s[k]) begin
          m_data_d[k]  = s_data_q[k];
          m_valid_d[k] = 1'b1;
          s_valid_d[k] = 1'b0;
        end else begin
          m_valid_d[k] = m_valid_q[k];
        end
      end else if (acc_s[k] && (!m_valid_q[k] || pop_s[k])) begin
        m_data_d[k]  = up_data_s[k];
        m_valid_d[k] = 1'b1;
      end else if (acc_s[k]) begin
        // Main is held and not leaving: park the new item in the skid.
        s_data_d[k]  = up_data_s[k];
        s_valid_d[k] = 1'b1;
      end else if (pop_s[k]) begin
        m_valid_d[k] = 1'b0;
      end else begin
        m_valid_d[k] = m_valid_q[k];
      end
    end
    // Flush drops every entry; data registers keep their stale contents.
    if (flush) begin
      m_valid_d = '0;
      s_valid_d = '0;
    end else begin
      s_valid_d = s_valid_d;
    end
  end

  // Occupancy next state: only chain-boundary transfers change the count.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (in_xfer_s && !out_xfer_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (out_xfer_s && !in_xfer_s) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid_q <= '0;
      s_valid_q <= '0;
      m_data_q  <= '0;
      s_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
